mult_share_arbiter: RTL and testbench

- Round-robin arbiter and scheduler that shares one mult_unsigned_pipe instance between NREQ requesters.
- Accepts at most one operand pair per cycle through a valid/ready handshake per requester.
- Drives the multiplier inputs from registers and tracks the owner tag of each in-flight product through a delay line matched to the multiplier latency.
- Returns each result to its requester. A hold/drain control lets the multiplier's precision parameters be changed safely between batches.

---
 rtl/mult_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler that shares one pipelined multiplier between NREQ requesters.
// An owner-tag delay line, matched to the multiplier latency, routes each product back to its requester.
module mult_share_arbiter #(
  parameter int NREQ = 4,   // 2..8
  parameter int W1   = 6,
  parameter int W2   = 7,
  parameter int WO   = 17,
  parameter int PIP  = 1    // multiplier pipeline depth, >= 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W1-1:0] req_in1,
  input  logic [NREQ*W2-1:0] req_in2,
  input  logic               hold,
  output logic               idle,
  output logic [W1-1:0]      mul_in1,
  output logic [W2-1:0]      mul_in2,
  input  logic [WO-1:0]      mul_out,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [WO-1:0]      rsp_data,
  output logic [1:0]         o_dbg_state
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(PIP + 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    w_ptr_nxt;
  logic [GW-1:0]    w_off;
  logic [GW:0]      w_sum;
  logic [GW-1:0]    w_grant_idx;
  logic [2*NREQ-1:0] w_rot;
  logic             w_found;
  logic             w_accept;
  logic             w_retire;
  logic [NREQ-1:0]  w_grant_oh;
  logic [NREQ-1:0]  w_rsp_oh;
  logic [PIP:0]     r_tag_v;
  logic [GW-1:0]    r_tag_id [PIP+1];
  logic [CW-1:0]    r_cnt;
  logic [W1-1:0]    r_mul_in1;
  logic [W2-1:0]    r_mul_in2;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WO-1:0]    r_rsp_data;

  // Handshake: a requester holds req_valid and its operands until the edge where
  // req_valid & req_ready are both high; ready depends only on valid, pointer, state and hold.
  always_comb begin
    w_rot   = {req_valid, req_valid} >> r_ptr;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = GW'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (GW+1)'(NREQ)) begin
      w_grant_idx = GW'(w_sum - (GW+1)'(NREQ));
    end else begin
      w_grant_idx = GW'(w_sum);
    end
  end

  assign w_accept  = w_found && (r_state == ST_RUN) && !hold;
  assign w_ptr_nxt = (w_grant_idx == GW'(NREQ - 1)) ? '0 : w_grant_idx + GW'(1);
  assign w_retire  = r_tag_v[PIP];

  always_comb begin
    w_grant_oh = '0;
    w_rsp_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_grant_oh[i] = w_accept && (w_grant_idx == GW'(i));
      w_rsp_oh[i]   = w_retire && (r_tag_id[PIP] == GW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (hold) w_state_nxt = ST_DRAIN;
      // Releasing hold mid-drain resumes at once; the tag line still delivers what is in flight.
      ST_DRAIN: begin
        if (!hold) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE:  if (!hold) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_RUN;
      r_ptr       <= '0;
      r_tag_v     <= '0;
      for (int s = 0; s <= PIP; s++) r_tag_id[s] <= '0;
      r_cnt       <= '0;
      r_mul_in1   <= '0;
      r_mul_in2   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tag_v     <= {r_tag_v[PIP-1:0], w_accept};
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s <= PIP; s++) r_tag_id[s] <= r_tag_id[s-1];
      if (w_accept) begin
        r_ptr     <= w_ptr_nxt;
        r_mul_in1 <= req_in1[w_grant_idx*W1 +: W1];
        r_mul_in2 <= req_in2[w_grant_idx*W2 +: W2];
      end
      r_rsp_valid <= w_rsp_oh;
      if (w_retire) r_rsp_data <= mul_out;
      case ({w_accept, w_retire})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign req_ready   = w_grant_oh;
  assign idle        = (r_state == ST_IDLE);
  assign mul_in1     = r_mul_in1;
  assign mul_in2     = r_mul_in2;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: PIP=1 and PIP=3 instances share one stimulus stream,
// each with its own behavioural multiplier and expected-response queue.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W1   = 6;
  localparam int W2   = 7;
  localparam int WO   = 17;
  localparam int PIP0 = 1;
  localparam int PIP1 = 3;
  localparam int FSH  = 4;   // Q1.5 x Q1.6 -> Q2.15
  localparam int S_RUN = 0, S_DRAIN = 1, S_IDLE = 2;

  typedef struct packed {
    logic [31:0]   due;
    logic [7:0]    id;
    logic [WO-1:0] data;
  } exp_t;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*W1-1:0] req_in1;
  logic [NREQ*W2-1:0] req_in2;
  logic               hold;
  logic [NREQ-1:0]    req_ready [2];
  logic               idle [2];
  logic [W1-1:0]      mul_in1 [2];
  logic [W2-1:0]      mul_in2 [2];
  logic [WO-1:0]      mul_out [2];
  logic [NREQ-1:0]    rsp_valid [2];
  logic [WO-1:0]      rsp_data [2];
  logic [1:0]         dbg_state [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   dq0[$];
  int   dq1[$];
  int   m_ptr;
  int   m_state [2];
  logic [W1-1:0]   m_last1;
  logic [W2-1:0]   m_last2;
  logic [NREQ-1:0] pending;
  logic [W1-1:0]   op1 [NREQ];
  logic [W2-1:0]   op2 [NREQ];

  mult_share_arbiter #(.NREQ(NREQ), .W1(W1), .W2(W2), .WO(WO), .PIP(PIP0)) u_dut0 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_in1(req_in1), .req_in2(req_in2), .hold(hold), .idle(idle[0]),
    .mul_in1(mul_in1[0]), .mul_in2(mul_in2[0]), .mul_out(mul_out[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .o_dbg_state(dbg_state[0])
  );

  mult_share_arbiter #(.NREQ(NREQ), .W1(W1), .W2(W2), .WO(WO), .PIP(PIP1)) u_dut1 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_in1(req_in1), .req_in2(req_in2), .hold(hold), .idle(idle[1]),
    .mul_in1(mul_in1[1]), .mul_in2(mul_in2[1]), .mul_out(mul_out[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .o_dbg_state(dbg_state[1])
  );

  // ---------------- clock / cycle counter / multiplier models ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [WO-1:0] ref_mul(input logic [W1-1:0] a, input logic [W2-1:0] b);
    return WO'((32'(a) * 32'(b)) << FSH);
  endfunction

  logic [WO-1:0] mp0 [PIP0];
  logic [WO-1:0] mp1 [PIP1];
  always @(posedge CLK) begin
    mp0[0] <= ref_mul(mul_in1[0], mul_in2[0]);
    for (int s = 1; s < PIP0; s++) mp0[s] <= mp0[s-1];
    mp1[0] <= ref_mul(mul_in1[1], mul_in2[1]);
    for (int s = 1; s < PIP1; s++) mp1[s] <= mp1[s-1];
  end
  assign mul_out[0] = mp0[PIP0-1];
  assign mul_out[1] = mp1[PIP1-1];

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: got %0h", nm, cyc, act);
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    dq0.delete();
    dq1.delete();
    m_ptr      = 0;
    m_state[0] = S_RUN;
    m_state[1] = S_RUN;
    m_last1    = '0;
    m_last2    = '0;
    pending    = '0;
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_mul_in1_%0d", tag, k), 64'(mul_in1[k]), 64'(0));
      chk($sformatf("%s_mul_in2_%0d", tag, k), 64'(mul_in2[k]), 64'(0));
      chk($sformatf("%s_rsp_valid_%0d", tag, k), 64'(rsp_valid[k]), 64'(0));
      chk($sformatf("%s_rsp_data_%0d", tag, k), 64'(rsp_data[k]), 64'(0));
      chk($sformatf("%s_idle_%0d", tag, k), 64'(idle[k]), 64'(0));
      chk($sformatf("%s_ready_%0d", tag, k), 64'(req_ready[k]), 64'(0));
    end
  endtask

  // ---------------- driver: one clock cycle of stimulus plus reference model ----------------
  task automatic step(input logic [NREQ-1:0] mask, input int pct, input logic h);
    int g;
    int ns;
    int cnt;
    logic [NREQ-1:0] exp_rdy;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!pending[i] && mask[i] && ($urandom_range(99) < pct)) begin
        pending[i] = 1'b1;
        op1[i] = W1'($urandom_range((1 << W1) - 1));
        op2[i] = W2'($urandom_range((1 << W2) - 1));
      end
      req_in1[i*W1 +: W1] = op1[i];
      req_in2[i*W2 +: W2] = op2[i];
    end
    req_valid = pending;
    hold = h;
    #1;
    g = (m_state[0] == S_RUN && !h) ? exp_grant(pending, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_pip%0d", k ? PIP1 : PIP0), 64'(req_ready[k]), 64'(exp_rdy));
      chk($sformatf("idle_pip%0d", k ? PIP1 : PIP0), 64'(idle[k]), 64'(m_state[k] == S_IDLE));
      chk($sformatf("mul_in1_pip%0d", k ? PIP1 : PIP0), 64'(mul_in1[k]), 64'(m_last1));
      chk($sformatf("mul_in2_pip%0d", k ? PIP1 : PIP0), 64'(mul_in2[k]), 64'(m_last2));
    end
    // advance the reference model across the coming edge
    for (int k = 0; k < 2; k++) begin
      cnt = k ? dq1.size() : dq0.size();
      if (m_state[k] == S_RUN) ns = h ? S_DRAIN : S_RUN;
      else if (!h) ns = S_RUN;
      else if (m_state[k] == S_DRAIN && cnt == 0) ns = S_IDLE;
      else ns = m_state[k];
      m_state[k] = ns;
    end
    if (dq0.size() > 0 && dq0[0] == cyc + 1) void'(dq0.pop_front());
    if (dq1.size() > 0 && dq1[0] == cyc + 1) void'(dq1.pop_front());
    if (g >= 0) begin
      dq0.push_back(cyc + PIP0 + 2);
      dq1.push_back(cyc + PIP1 + 2);
      exp_q0.push_back('{due: 32'(cyc + PIP0 + 2), id: 8'(g), data: ref_mul(op1[g], op2[g])});
      exp_q1.push_back('{due: 32'(cyc + PIP1 + 2), id: 8'(g), data: ref_mul(op1[g], op2[g])});
      m_last1 = op1[g];
      m_last2 = op2[g];
      m_ptr = (g + 1) % NREQ;
      pending[g] = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    int n;
    string nm;
    nm = $sformatf("pip%0d", k ? PIP1 : PIP0);
    n = k ? exp_q1.size() : exp_q0.size();
    e = '0;
    if (n > 0) e = k ? exp_q1[0] : exp_q0[0];
    if (rsp_valid[k] != '0) begin
      if (n == 0) begin
        fail({"rsp_unexpected_", nm}, 64'(rsp_valid[k]));
      end else begin
        if (k) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
        chk({"rsp_valid_", nm}, 64'(rsp_valid[k]), 64'(NREQ'(1) << e.id));
        chk({"rsp_data_", nm}, 64'(rsp_data[k]), 64'(e.data));
        chk({"rsp_time_", nm}, 64'(cyc), 64'(e.due));
      end
    end else if (n > 0 && int'(e.due) <= cyc) begin
      fail({"rsp_missing_", nm}, 64'(e.due));
      if (k) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #3;
      mon(0);
      mon(1);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic hr;
    int   mask;
    int   pct;
    RST = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_in1 = '0;
    req_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      op1[i] = '0;
      op2[i] = '0;
    end
    model_clear();
    #3 RST = 1'b0;
    #1 reset_checks("por");
    repeat (2) @(posedge CLK);
    #4 RST = 1'b1;

    // single request from requester 2: 1.0 x 1.5
    pending[2] = 1'b1;
    op1[2] = 6'b100000;
    op2[2] = 7'b1100000;
    step('0, 0, 1'b0);
    repeat (3) step('0, 0, 1'b0);
    chk("dir1_rsp_valid_pip1", 64'(rsp_valid[0]), 64'(4'b0100));
    chk("dir1_rsp_data_pip1", 64'(rsp_data[0]), 64'(17'h0C000));
    repeat (2) step('0, 0, 1'b0);
    chk("dir1_rsp_valid_pip3", 64'(rsp_valid[1]), 64'(4'b0100));
    chk("dir1_rsp_data_pip3", 64'(rsp_data[1]), 64'(17'h0C000));

    // single request from requester 1: 1.75 x 1.75
    pending[1] = 1'b1;
    op1[1] = 6'b111000;
    op2[1] = 7'b1110000;
    step('0, 0, 1'b0);
    repeat (3) step('0, 0, 1'b0);
    chk("dir2_rsp_valid_pip1", 64'(rsp_valid[0]), 64'(4'b0010));
    chk("dir2_rsp_data_pip1", 64'(rsp_data[0]), 64'(17'h18800));
    repeat (4) step('0, 0, 1'b0);

    // all requesters continuously valid, then hold with products in flight
    repeat (12) step('1, 100, 1'b0);
    repeat (10) step('1, 100, 1'b1);
    repeat (6) step('1, 100, 1'b0);
    repeat (8) step('0, 0, 1'b0);

    // reset one cycle after an accept discards the in-flight product
    pending[1] = 1'b1;
    op1[1] = W1'($urandom_range((1 << W1) - 1));
    op2[1] = W2'($urandom_range((1 << W2) - 1));
    step('0, 0, 1'b0);
    @(posedge CLK);
    #4;
    RST = 1'b0;
    req_valid = '0;
    #1;
    reset_checks("rst_pulse");
    model_clear();
    @(posedge CLK);
    #4 RST = 1'b1;

    // fairness between requesters 0 and 3 from pointer 0
    repeat (10) step(4'b1001, 100, 1'b0);
    repeat (6) step('0, 0, 1'b0);

    // randomized traffic with hold toggling
    hr = 1'b0;
    for (int b = 0; b < 12; b++) begin
      mask = $urandom_range(1, (1 << NREQ) - 1);
      pct  = $urandom_range(20, 100);
      for (int s = 0; s < 100; s++) begin
        if ($urandom_range(99) < 4) hr = ~hr;
        step(NREQ'(mask), pct, hr);
      end
    end

    // drain: every expected response must have arrived
    repeat (12) step('0, 0, 1'b0);
    chk("drain_empty_pip1", 64'(exp_q0.size()), 64'(0));
    chk("drain_empty_pip3", 64'(exp_q1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
